// File: rtl/led_rate_sequencer_if.sv
// Control and status bundle between the board control logic and led_rate_sequencer.
interface led_rate_sequencer_if;
    // Controls are single-cycle or level signals sampled on the rising clock edge.
    // There is no valid/ready handshake: i_start is a request taken only in IDLE,
    // i_hold is a level, and i_abort is a request with top priority. Every status
    // output is registered.
    logic       i_start;
    logic       i_hold;
    logic       i_abort;
    logic       o_select_s1;
    logic       o_select_s0;
    logic       o_enable;
    logic       o_busy;
    logic [1:0] o_step;
    logic       o_done;

    modport master (
        output i_start, i_hold, i_abort,
        input  o_select_s1, o_select_s0, o_enable, o_busy, o_step, o_done
    );

    modport slave (
        input  i_start, i_hold, i_abort,
        output o_select_s1, o_select_s0, o_enable, o_busy, o_step, o_done
    );
endinterface

// File: rtl/led_rate_sequencer.sv
// Steps the blink-rate selects through SEQ_PATTERN, DWELL_CYCLES cycles per step.
// Define LED_SEQ_LOOP_EN to wrap back to step 0 forever instead of finishing once.
module led_rate_sequencer #(
    parameter logic [31:0] DWELL_CYCLES = 32'd200000,
    parameter int unsigned NUM_STEPS    = 4,
    parameter logic [7:0]  SEQ_PATTERN  = 8'b01_00_01_00
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    led_rate_sequencer_if.slave   seq_if,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] DWELL_LAST = DWELL_CYCLES - 32'd1;
    localparam logic [1:0]  LAST_STEP  = 2'(NUM_STEPS - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  step_q, step_d;
    logic [1:0]  sel_q, sel_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  step_inc;

    assign step_inc = step_q + 2'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 32'd0;
            step_q   <= 2'd0;
            sel_q    <= 2'd0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            sel_q    <= sel_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        sel_d    = sel_q;
        enable_d = enable_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (seq_if.i_start && !seq_if.i_abort) begin
                    state_d  = ST_RUN;
                    cnt_d    = 32'd0;
                    step_d   = 2'd0;
                    sel_d    = SEQ_PATTERN[1:0];
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (seq_if.i_abort) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 32'd0;
                    step_d   = 2'd0;
                    sel_d    = 2'd0;
                    enable_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (state_q == ST_HOLD && seq_if.i_hold) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == DWELL_LAST) begin
                    // Terminal count wins over a hold arriving in the same cycle.
                    if (step_q != LAST_STEP) begin
                        step_d  = step_inc;
                        sel_d   = SEQ_PATTERN[{step_inc, 1'b0} +: 2];
                        cnt_d   = 32'd0;
                        state_d = seq_if.i_hold ? ST_HOLD : ST_RUN;
                    end else begin
`ifdef LED_SEQ_LOOP_EN
                        step_d  = 2'd0;
                        sel_d   = SEQ_PATTERN[1:0];
                        cnt_d   = 32'd0;
                        done_d  = 1'b1;
                        state_d = seq_if.i_hold ? ST_HOLD : ST_RUN;
`else
                        state_d  = ST_DONE;
                        cnt_d    = 32'd0;
                        step_d   = 2'd0;
                        sel_d    = 2'd0;
                        enable_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
`endif
                    end
                end else if (seq_if.i_hold) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign seq_if.o_select_s1 = sel_q[1];
    assign seq_if.o_select_s0 = sel_q[0];
    assign seq_if.o_enable    = enable_q;
    assign seq_if.o_busy      = busy_q;
    assign seq_if.o_step      = step_q;
    assign seq_if.o_done      = done_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_led_rate_sequencer.sv
// Directed bench for led_rate_sequencer with DWELL_CYCLES=4, NUM_STEPS=4, default pattern.
module tb_led_rate_sequencer;

    localparam logic [31:0] DWELL = 32'd4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_rate_sequencer_if bus();
    logic [1:0] dbg_state;

    led_rate_sequencer #(
        .DWELL_CYCLES (DWELL),
        .NUM_STEPS    (4),
        .SEQ_PATTERN  (8'b01_00_01_00)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .seq_if      (bus),
        .dbg_state_o (dbg_state)
    );

    // {s1, s0, enable, busy, step[1:0], done}
    logic [6:0] obs;
    assign obs = {bus.o_select_s1, bus.o_select_s0, bus.o_enable, bus.o_busy, bus.o_step, bus.o_done};

    logic [1:0] sel_tab [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [6:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] run_vec(input logic [1:0] step, input logic done);
        return {sel_tab[step], 1'b1, 1'b1, step, done};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic h, input logic a);
        bus.i_start = s;
        bus.i_hold  = h;
        bus.i_abort = a;
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("reset_outputs", obs, 7'd0);
        check("reset_state", {5'd0, dbg_state}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_after_release", obs, 7'd0);

        // start together with abort in IDLE stays in IDLE
        drive(1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("start_abort_idle", obs, 7'd0);
        check("start_abort_state", {5'd0, dbg_state}, 7'd0);

`ifdef LED_SEQ_LOOP_EN
        // wrap every 16 cycles with a done pulse, enable never drops
        for (int c = 0; c < 41; c++) begin
            if (c > 0 && (c % 16) == 0) exp_q.push_back({2'b00, 1'b1, 1'b1, 2'b00, 1'b1});
            else exp_q.push_back(run_vec(2'((c % 16) / 4), 1'b0));
        end
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 41; c++) begin
            check($sformatf("loop c=%0d", c), obs, exp_q.pop_front());
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("loop_abort", obs, 7'd0);
`else
        // one-shot run, with an ignored start pulse during step 1
        for (int c = 0; c < 16; c++) exp_q.push_back(run_vec(2'(c / 4), 1'b0));
        exp_q.push_back(7'b00_0_0_00_1);
        exp_q.push_back(7'd0);
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 18; c++) begin
            check($sformatf("oneshot c=%0d", c), obs, exp_q.pop_front());
            if (c == 16) check("done_state", {5'd0, dbg_state}, 7'd3);
            drive(c == 4, 1'b0, 1'b0);
            tick();
        end
        check("idle_after_done", {5'd0, dbg_state}, 7'd0);

        // hold for 10 cycles at counter=2 of step 1: step 1 lasts 14 cycles
        for (int c = 0; c < 26; c++) begin
            if (c < 4)       exp_q.push_back(run_vec(2'd0, 1'b0));
            else if (c < 18) exp_q.push_back(run_vec(2'd1, 1'b0));
            else if (c < 22) exp_q.push_back(run_vec(2'd2, 1'b0));
            else             exp_q.push_back(run_vec(2'd3, 1'b0));
        end
        exp_q.push_back(7'b00_0_0_00_1);
        exp_q.push_back(7'd0);
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 28; c++) begin
            check($sformatf("hold c=%0d", c), obs, exp_q.pop_front());
            if (c == 10) check("hold_state", {5'd0, dbg_state}, 7'd2);
            drive(1'b0, (c >= 6 && c <= 15), 1'b0);
            tick();
        end
`endif

        // abort together with hold in step 3: back to IDLE, no done pulse
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c < 13; c++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        check("abort_pre_step3", obs, run_vec(2'd3, 1'b0));
        drive(1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("abort_outputs", obs, 7'd0);
        check("abort_state", {5'd0, dbg_state}, 7'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("abort_no_done c=%0d", c), obs, 7'd0);
        end

        // reset asserted mid-run clears outputs without a clock edge
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 9; c++) tick();
        check("pre_reset_step2", obs, run_vec(2'd2, 1'b0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", obs, 7'd0);
        check("async_reset_state", {5'd0, dbg_state}, 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_mid_reset", obs, 7'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
